path_delay_launcher: RTL

//  Stimulus/capture end for a single combinational test path such as the spy

---
 rtl/path_delay_launcher_if.sv | 30 +++
 rtl/path_delay_launcher.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/path_delay_launcher_if.sv
// rtl/path_delay_launcher_if.sv - control, path and statistics bundle for path_delay_launcher
interface path_delay_launcher_if #(
  parameter int N_TRIALS = 16,
  parameter int CNT_W    = 16
);
  localparam int TC_W  = $clog2(N_TRIALS) + 1;
  localparam int SUM_W = CNT_W + TC_W;

  logic             start;
  logic             path_in;
  logic             path_out;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             stuck;
  logic [CNT_W-1:0] lat_min;
  logic [CNT_W-1:0] lat_max;
  logic [SUM_W-1:0] lat_sum;
  logic [TC_W-1:0]  trial_cnt;

  modport master (
    output start, path_out,
    input  path_in, busy, done, timeout, stuck, lat_min, lat_max, lat_sum, trial_cnt
  );

  modport slave (
    input  start, path_out,
    output path_in, busy, done, timeout, stuck, lat_min, lat_max, lat_sum, trial_cnt
  );
endinterface

// File: rtl/path_delay_launcher.sv
// rtl/path_delay_launcher.sv - launches alternating edges into a test path and measures settle latency
module path_delay_launcher #(
  parameter int N_TRIALS   = 16,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int SETTLE_CYC = 8,
  parameter bit POLARITY   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  path_delay_launcher_if.slave bus
);
  localparam int TC_W  = $clog2(N_TRIALS) + 1;
  localparam int SUM_W = CNT_W + TC_W;
  localparam int SC_W  = $clog2(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_path_in;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic             r_stuck;
  logic [SC_W-1:0]  r_scnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_lat_min;
  logic [CNT_W-1:0] r_lat_max;
  logic [SUM_W-1:0] r_lat_sum;
  logic [TC_W-1:0]  r_trial_cnt;
  logic             w_exp;

  // Level the synchronized output must reach once the current drive has propagated.
  assign w_exp = r_path_in ^ POLARITY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_path_in   <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_stuck     <= 1'b0;
      r_scnt      <= '0;
      r_cnt       <= '0;
      r_lat_min   <= '1;
      r_lat_max   <= '0;
      r_lat_sum   <= '0;
      r_trial_cnt <= '0;
    end else begin
      r_sync1 <= bus.path_out;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_timeout   <= 1'b0;
            r_stuck     <= 1'b0;
            r_lat_min   <= '1;
            r_lat_max   <= '0;
            r_lat_sum   <= '0;
            r_trial_cnt <= '0;
            r_busy      <= 1'b1;
            r_scnt      <= '0;
            r_state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_scnt == SC_W'(SETTLE_CYC - 1)) begin
            if (r_sync2 != w_exp) begin
              r_stuck <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_LAUNCH;
            end
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        S_LAUNCH: begin
          r_path_in <= ~r_path_in;
          r_cnt     <= CNT_W'(1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // cnt includes the two synchronizer stages plus this compare edge.
          if (r_sync2 == w_exp) begin
            if (r_cnt < r_lat_min) r_lat_min <= r_cnt;
            if (r_cnt > r_lat_max) r_lat_max <= r_cnt;
            r_lat_sum   <= r_lat_sum + SUM_W'(r_cnt);
            r_trial_cnt <= r_trial_cnt + 1'b1;
            r_state     <= S_NEXT;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (r_trial_cnt == TC_W'(N_TRIALS)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_scnt  <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.path_in   = r_path_in;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.stuck     = r_stuck;
  assign bus.lat_min   = r_lat_min;
  assign bus.lat_max   = r_lat_max;
  assign bus.lat_sum   = r_lat_sum;
  assign bus.trial_cnt = r_trial_cnt;
endmodule
